instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Parametrised instruction-fetch stage for the RISC-V core. It replaces the bare program counter with a fetch engine: it owns the fetch PC, drives the synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO. The FIFO feeds decode over a valid/ready handshake. Taken branches and jumps redirect fetch and flush all buffered and in-flight instructions.

## Interface
Parameters:
- PC_WIDTH, 16, width of the PC and the instruction-memory address.
- INST_WIDTH, 32, instruction width.
- FIFO_DEPTH, 4, number of buffer entries; power of two, ≥ 4.
- RESET_PC, 0, fetch PC after reset.
- PC_STEP, 1, PC increment per instruction (word addressing).

Ports (one clock; reset is asynchronous and active-high):
- sysCLK  in  1  clock; all state updates on the rising edge.
- pRST  in  1  asynchronous active-high reset.
- imemReq  out  1  fetch request this cycle.
- imemAddr  out  PC_WIDTH  fetch address; equals the current fetch PC.
- imemData  in  INST_WIDTH  instruction memory data, valid the cycle after a request.
- brTaken  in  1  redirect strobe from execute.
- brTarget  in  PC_WIDTH  redirect address.
- instValid  out  1  FIFO head is valid.
- instReady  in  1  decode accepts the head.
- instOut  out  INST_WIDTH  head instruction.
- instPC  out  PC_WIDTH  head PC.
- instPCNext  out  PC_WIDTH  head PC + PC_STEP, modulo 2^PC_WIDTH (link value for JAL/JALR writeback).
- fifoCount  out  log2(FIFO_DEPTH)+1  occupied entries.

## Operation
- State:
  - fetchPC register.
  - inflight flag: a request was issued last cycle.
  - inflightPC register.
  - FIFO of {instruction, PC}, with read pointer, write pointer and count.
- Issue: imemReq = !pRST && !brTaken && (fifoCount + inflight < FIFO_DEPTH).
  - On issue: inflight ← 1, inflightPC ← fetchPC, fetchPC ← fetchPC + PC_STEP.
  - Otherwise: inflight ← 0.
- Response: in a cycle where inflight = 1, imemData is written into the FIFO with inflightPC, unless brTaken is high in that cycle.
- Pop: a pop occurs when instValid && instReady; the read pointer advances.
- Push and pop in the same cycle: count is unchanged, and both pointers advance.
- Redirect: brTaken has priority over issue, push and pop.
  - At the edge: count ← 0, both pointers ← 0, inflight ← 0, fetchPC ← brTarget.
  - The response arriving in that cycle is discarded.
  - No request is issued in that cycle.
- Outputs are driven from the FIFO head. When instValid = 0, instOut, instPC and instPCNext read 0.
- Overflow is structurally impossible because issue is credit-gated; the bench asserts count ≤ FIFO_DEPTH.
- fetchPC and the FIFO pointers wrap modulo their widths; no flag is raised on wrap.
- Reset, asynchronous, at any time including mid-redirect or while a request is in flight:
  - fetchPC ← RESET_PC; FIFO empty; inflight ← 0.
  - Outputs during reset: imemReq=0, imemAddr=RESET_PC, instValid=0, instOut=0, instPC=0, instPCNext=0, fifoCount=0.
  - A memory response arriving in the first cycle after reset is ignored because inflight = 0.

## Timing
- Fetch latency: request in cycle t, data captured into the FIFO at the end of t+1, instValid in t+2. There is no bypass.
- After pRST falls, the first request (RESET_PC) is issued in cycle 0 and its instruction is presented in cycle 2.
- Throughput: one instruction per cycle sustained while instReady=1 (steady state has count ≤ 1 and inflight = 1).
- Redirect: brTaken in cycle t → request for brTarget in t+1 → instValid with instPC=brTarget in t+3. instValid is 0 during t+1 and t+2.
- Backpressure:
  - With instReady=0, issue stops once fifoCount + inflight = FIFO_DEPTH.
  - When instReady returns to 1, issue resumes in the same cycle the credit frees. The credit is seen one cycle after the pop, because the pop updates count at the edge.
- All outputs except imemReq are registered or FIFO-read. imemReq depends combinationally on brTaken and pRST.

## Test plan
- Reset then free run, instReady=1, memory returns 0x1000_0000 + address: instPC sequence 0,1,2,… from cycle 2, one per cycle; instOut = 0x1000_0000 + instPC; instPCNext = instPC+1.
- Backpressure with instReady held 0 from cycle 0: fifoCount saturates at 4, imemReq falls after 4 issues, fetchPC = 4. Raising instReady drains PCs 0,1,2,3, then 4 follows with no gap or duplicate.
- Redirect, brTaken=1 with brTarget=0x0040 while the FIFO holds 3 entries and one request is in flight: the next cycle has fifoCount=0 and instValid=0; instPC=0x0040 appears exactly 3 cycles after brTaken; no stale PC is ever presented.
- Redirect coinciding with a pop and a push in the same cycle: the redirect wins, fifoCount=0 after the edge, and the popped entry is consumed once.
- PC wrap, PC_WIDTH=16, brTarget=0xFFFE: instPC sequence 0xFFFE, 0xFFFF, 0x0000; instPCNext for 0xFFFF reads 0x0000.
- Reset mid-stream with 2 entries buffered and one in flight: outputs zero immediately (asynchronously); after release, fetch restarts at RESET_PC and the stale in-flight data never appears.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives a synchronous instruction memory
// and buffers {instruction, PC} pairs in a FIFO that feeds decode over valid/ready.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH   = 16,
  parameter int                  INST_WIDTH = 32,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP    = {{(PC_WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                          sysCLK,
  input  logic                          pRST,
  output logic                          imemReq,
  output logic [PC_WIDTH-1:0]           imemAddr,
  input  logic [INST_WIDTH-1:0]         imemData,
  input  logic                          brTaken,
  input  logic [PC_WIDTH-1:0]           brTarget,
  output logic                          instValid,
  input  logic                          instReady,
  output logic [INST_WIDTH-1:0]         instOut,
  output logic [PC_WIDTH-1:0]           instPC,
  output logic [PC_WIDTH-1:0]           instPCNext,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  // Handshake: an entry moves to decode on any rising edge where instValid && instReady
  // and brTaken is low; a redirect flushes the head instead of handing it over twice.

  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [INST_WIDTH-1:0] inst_mem_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem_q   [FIFO_DEPTH];

  logic [CW:0] credit_used;
  logic        issue;
  logic        push;
  logic        pop;
  logic        head_valid;

  assign head_valid  = (count_q != '0);
  // In-flight requests reserve a slot, so a response always finds room.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue       = !pRST && !brTaken && (credit_used < DEPTH_C);
  assign push        = inflight_q && !brTaken;
  assign pop         = head_valid && instReady && !brTaken;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (brTaken) begin
      fetch_pc_d = brTarget;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_STEP;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge sysCLK or posedge pRST) begin
    if (pRST) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are meaningful.
  always_ff @(posedge sysCLK) begin
    if (!pRST && push) begin
      inst_mem_q[wr_ptr_q] <= imemData;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign imemReq    = issue;
  assign imemAddr   = fetch_pc_q;
  assign instValid  = head_valid;
  assign instOut    = head_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign instPC     = head_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign instPCNext = head_valid ? (pc_mem_q[rd_ptr_q] + PC_STEP) : '0;
  assign fifoCount  = count_q;

endmodule
